// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ clients.
// It launches one frame per grant, follows the UART busy flag to spot frame
// completion, holds an inter-frame gap and aborts launches that never start.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int data_width     = 8,
  parameter int LAUNCH_TIMEOUT = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  input  logic [NUM_REQ-1:0]            req_par_type,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_en,
  output logic [data_width-1:0]         uart_data,
  output logic                          uart_par_en,
  output logic                          uart_par_type,
  input  logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    active_id,
  output logic                          sched_busy,
  output logic                          frame_done,
  output logic                          timeout_err
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (LAUNCH_TIMEOUT > GAP_CYCLES) ? LAUNCH_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LT_LAST  = CNT_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [ID_W-1:0]         rr_ptr, rr_ptr_d;
  logic [NUM_REQ-1:0]      grant_d;
  logic                    tx_en_d;
  logic [data_width-1:0]   data_d;
  logic                    par_en_d, par_type_d;
  logic [ID_W-1:0]         id_d;
  logic                    done_d, to_d;
  logic [ID_W-1:0]         sel, idx;
  logic                    sel_vld;

  // Where the scheduler is after a frame or timeout; a zero gap skips GAP.
  state_t post_frame;
  assign post_frame = (GAP_CYCLES == 0) ? IDLE : GAP;

  assign sched_busy = (state != IDLE);

  // Round-robin pick: first set request at or above rr_ptr, wrapping around.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!sel_vld && req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; outputs hold unless a state acts on them.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rr_ptr_d   = rr_ptr;
    grant_d    = '0;
    tx_en_d    = tx_en;
    data_d     = uart_data;
    par_en_d   = uart_par_en;
    par_type_d = uart_par_type;
    id_d       = active_id;
    done_d     = 1'b0;
    to_d       = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_d    = NUM_REQ'(1) << sel;
          data_d     = req_data[int'(sel)*data_width +: data_width];
          par_en_d   = req_par_en[sel];
          par_type_d = req_par_type[sel];
          id_d       = sel;
          tx_en_d    = 1'b1;
          rr_ptr_d   = ID_W'((int'(sel) + 1) % NUM_REQ);
          cnt_d      = '0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        // An acknowledging busy takes priority over an expiring timeout.
        if (busy) begin
          tx_en_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt == LT_LAST) begin
          tx_en_d = 1'b0;
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = post_frame;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = post_frame;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset returns everything to idle defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      grant         <= '0;
      tx_en         <= 1'b0;
      uart_data     <= '0;
      uart_par_en   <= 1'b0;
      uart_par_type <= 1'b0;
      active_id     <= '0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rr_ptr        <= rr_ptr_d;
      grant         <= grant_d;
      tx_en         <= tx_en_d;
      uart_data     <= data_d;
      uart_par_en   <= par_en_d;
      uart_par_type <= par_type_d;
      active_id     <= id_d;
      frame_done    <= done_d;
      timeout_err   <= to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of expected grants checked by a
// monitor, plus directed timing checks; a second instance runs with no gap.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req0, req1;
  logic [31:0] req_data     = {8'd17, 8'd33, 8'd10, 8'd57};
  logic [3:0]  req_par_en   = 4'b1110;
  logic [3:0]  req_par_type = 4'b1010;

  logic [3:0]  grant0, grant1;
  logic        tx_en0, tx_en1;
  logic [7:0]  uart_data0, uart_data1;
  logic        par_en0, par_en1, par_type0, par_type1;
  logic        busy0, busy1;
  logic [1:0]  active_id0, active_id1;
  logic        sched_busy0, sched_busy1;
  logic        frame_done0, frame_done1;
  logic        timeout_err0, timeout_err1;
  logic        model_on0;

  uart_tx_arbiter #(.NUM_REQ(4), .data_width(8), .LAUNCH_TIMEOUT(16), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .req_data(req_data), .req_par_en(req_par_en),
    .req_par_type(req_par_type), .grant(grant0), .tx_en(tx_en0), .uart_data(uart_data0),
    .uart_par_en(par_en0), .uart_par_type(par_type0), .busy(busy0), .active_id(active_id0),
    .sched_busy(sched_busy0), .frame_done(frame_done0), .timeout_err(timeout_err0));

  uart_tx_arbiter #(.NUM_REQ(4), .data_width(8), .LAUNCH_TIMEOUT(16), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(req_data), .req_par_en(req_par_en),
    .req_par_type(req_par_type), .grant(grant1), .tx_en(tx_en1), .uart_data(uart_data1),
    .uart_par_en(par_en1), .uart_par_type(par_type1), .busy(busy1), .active_id(active_id1),
    .sched_busy(sched_busy1), .frame_done(frame_done1), .timeout_err(timeout_err1));

  always #5 clk = ~clk;

  typedef struct { int id; int data; bit pe; bit pt; } exp_t;
  exp_t sb[$];
  int dat_tab[4] = '{57, 10, 33, 17};
  bit pe_tab[4]  = '{0, 1, 1, 1};
  bit pt_tab[4]  = '{0, 1, 0, 1};

  int checks = 0, failures = 0;
  int n_grant0 = 0, n_done0 = 0;
  bit prev_done0 = 0, prev_to0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id = id; e.data = dat_tab[id]; e.pe = pe_tab[id]; e.pt = pt_tab[id];
    sb.push_back(e);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return grant0 != 4'd0;
      1: return busy0;
      2: return !busy0;
      3: return frame_done0;
      4: return timeout_err0;
      5: return grant1 != 4'd0;
      6: return frame_done1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance cycle by cycle until the selected condition holds; n = cycles waited.
  task automatic wait_for(input int which, input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk); #1;
      n++;
      if (cond(which)) return;
      if (n >= budget) begin
        checks++; failures++;
        $display("FAIL wait_%0d: got no event in %0d cycles, expected event", which, budget);
        n = -1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic finish_frame();
    int n;
    wait_for(3, 100, n);
    repeat (6) @(negedge clk);
    #1;
  endtask

  // UART stand-in for dut0: acknowledges tx_en after two cycles, busy for six.
  initial begin
    busy0 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_on0 && tx_en0) begin
        repeat (2) @(posedge clk);
        #1 busy0 = 1'b1;
        repeat (6) @(posedge clk);
        #1 busy0 = 1'b0;
      end
    end
  end

  // UART stand-in for dut1, always responsive.
  initial begin
    busy1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_en1) begin
        repeat (2) @(posedge clk);
        #1 busy1 = 1'b1;
        repeat (6) @(posedge clk);
        #1 busy1 = 1'b0;
      end
    end
  end

  // Monitor: compare each grant of dut0 against the scoreboard and police pulses.
  always @(negedge clk) begin
    exp_t e;
    int act_cnt;
    if (!rst) begin
      if (grant0 != 4'd0) begin
        n_grant0++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_grant: got grant=%0d, expected none", grant0);
        end else begin
          e = sb.pop_front();
          chk("grant_vec", grant0, 64'(4'b0001 << e.id));
          chk("active_id", active_id0, e.id);
          chk("uart_data", uart_data0, e.data);
          chk("uart_par_en", par_en0, e.pe);
          chk("uart_par_type", par_type0, e.pt);
          chk("tx_en_at_grant", tx_en0, 1);
        end
      end
      if (frame_done0) begin
        n_done0++;
        chk("done_single_pulse", prev_done0, 0);
      end
      if (timeout_err0) chk("timeout_single_pulse", prev_to0, 0);
      act_cnt = int'(grant0 != 4'd0) + int'(frame_done0) + int'(timeout_err0);
      if (act_cnt > 0) chk("pulse_exclusive", act_cnt, 1);
    end
    prev_done0 = frame_done0;
    prev_to0   = timeout_err0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, done_base, grant_base;
    rst = 1'b1; req0 = 4'd0; req1 = 4'd0; model_on0 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {grant0, tx_en0, uart_data0, par_en0, par_type0, active_id0,
                          sched_busy0, frame_done0, timeout_err0}, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Single requester 1
    push_exp(1);
    req0 = 4'b0010;
    wait_for(0, 20, n);
    chk("grant_latency", n, 1);
    chk("sched_busy_launch", sched_busy0, 1);
    req0 = 4'd0;
    wait_for(1, 30, n);
    chk("tx_en_before_ack", tx_en0, 1);
    @(negedge clk); #1;
    chk("tx_en_after_ack", tx_en0, 0);
    wait_for(3, 50, n);
    chk("busy_low_at_done", busy0, 0);
    @(negedge clk); #1;
    chk("done_one_cycle", frame_done0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("sched_busy_in_gap", sched_busy0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("sched_busy_idle", sched_busy0, 0);

    // Simultaneous requesters 0 and 3 from rr_ptr 0
    do_reset();
    push_exp(0); push_exp(3); push_exp(0); push_exp(3);
    req0 = 4'b1001;
    for (int k = 0; k < 4; k++) wait_for(0, 100, n);
    req0 = 4'd0;
    finish_frame();

    // Fairness: all four held for eight frames
    for (int k = 0; k < 8; k++) push_exp(k % 4);
    req0 = 4'b1111;
    for (int k = 0; k < 8; k++) wait_for(0, 100, n);
    req0 = 4'd0;
    finish_frame();

    // Launch timeout with a silent UART
    model_on0 = 1'b0;
    done_base = n_done0;
    push_exp(2); push_exp(2);
    req0 = 4'b0100;
    wait_for(0, 20, n);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (!tx_en0) break;
      cnt++;
    end
    chk("tx_en_high_cycles", cnt, 16);
    chk("timeout_err_pulse", timeout_err0, 1);
    wait_for(0, 20, n);
    chk("gap_after_timeout", n, 5);
    req0 = 4'd0;
    wait_for(4, 40, n);
    repeat (6) @(negedge clk);
    #1;
    chk("no_done_on_timeout", n_done0, done_base);
    model_on0 = 1'b1;

    // Reset while waiting for the frame to finish
    push_exp(1);
    req0 = 4'b0010;
    wait_for(0, 20, n);
    req0 = 4'd0;
    wait_for(1, 30, n);
    @(negedge clk); #1;
    done_base  = n_done0;
    grant_base = n_grant0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("reset_mid_frame", {grant0, tx_en0, uart_data0, par_en0, par_type0, active_id0,
                            sched_busy0, frame_done0, timeout_err0}, 0);
    rst = 1'b0;
    wait_for(2, 20, n);
    repeat (3) @(negedge clk);
    #1;
    chk("no_done_after_reset", n_done0, done_base);
    chk("no_grant_after_reset", n_grant0, grant_base);
    push_exp(0);
    req0 = 4'b1111;
    wait_for(0, 20, n);
    req0 = 4'd0;
    finish_frame();

    // Zero gap instance: back-to-back grants
    req1 = 4'b0011;
    wait_for(5, 20, n);
    chk("g0_first_grant", grant1, 4'b0001);
    wait_for(6, 50, n);
    @(negedge clk); #1;
    chk("g0_next_grant", grant1, 4'b0010);
    chk("g0_next_data", uart_data1, 10);
    req1 = 4'd0;
    wait_for(6, 50, n);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
